q_addr_sequencer: RTL

- Sits directly downstream of the index-compaction stage in the LDPC decoder check-node path.
- Takes the 35-slot x 14-bit packed index vector produced by that stage. A zero slot means empty; a nonzero slot is a 1-based variable-node index.
- Walks the nonzero slots and issues one zero-based LLR/q-memory address per valid/ready handshake, tagging the last one.
- Reports the row degree and pulses done when the row has been fully issued.

---
 rtl/ldpc_dec_pkg.sv | 24 ++
 rtl/lsb_prio_enc.sv | 26 ++
 rtl/q_addr_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ldpc_dec_pkg.sv
// Shared constants, FSM encoding and slot helper for the LDPC check-node address path.
// No logic of its own; imported by q_addr_sequencer and its helpers.
// Slot k of a packed index vector occupies bits [k*IDX_W +: IDX_W].
package ldpc_dec_pkg;

   localparam int IDX_W  = 14;
   localparam int N_SLOT = 35;
   localparam int SLOT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Pull one slot out of a packed index vector.
   function automatic logic [IDX_W-1:0] slot_extract(
      input logic [IDX_W*N_SLOT-1:0] vec,
      input logic [SLOT_W-1:0]       k
   );
      return vec[int'(k)*IDX_W +: IDX_W];
   endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and "exactly one bit set" flag.
// Purely combinational, zero latency.
// No flow control; an all-zero mask gives idx=0, onehot=0, one_set=0.
module lsb_prio_enc #(
   parameter int N = 35,
   parameter int W = 6
) (
   input  logic [N-1:0] mask,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         one_set
);

   // Scan from the top down so the lowest set bit is the final writer.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) idx = W'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign onehot  = mask & (~mask + 1'b1);
   assign one_set = (mask != '0) && (mask == onehot);

endmodule

// File: rtl/q_addr_sequencer.sv
// Walks nonzero slots of a packed index vector, issuing one zero-based q-memory address per beat.
// First beat the cycle after start; one beat per cycle under full ready; done the cycle after the last beat.
// Beats hold stable while addr_valid && !addr_ready; start is ignored outside IDLE.
// Optional build macro Q_ADDR_DEG_LIMIT_EN adds deg_limit / deg_err (truncate row at deg_limit beats).
module q_addr_sequencer
   import ldpc_dec_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [IDX_W*N_SLOT-1:0] index_vec,
   output logic                    addr_valid,
   input  logic                    addr_ready,
   output logic [IDX_W-1:0]        addr,
   output logic [SLOT_W-1:0]       addr_slot,
   output logic                    addr_last,
   output logic                    busy,
   output logic                    done,
   output logic [SLOT_W-1:0]       degree
`ifdef Q_ADDR_DEG_LIMIT_EN
   ,
   input  logic [SLOT_W-1:0]       deg_limit,
   output logic                    deg_err
`endif
);

   state_t                  state;
   logic [IDX_W*N_SLOT-1:0] snap;
   logic [N_SLOT-1:0]       pend_mask;
   logic [N_SLOT-1:0]       start_mask;
   logic [N_SLOT-1:0]       cur_oh;
   logic [SLOT_W-1:0]       cur_slot;
   logic [IDX_W-1:0]        cur_val;
   logic                    one_left;
   logic                    lim_hit;
   logic                    beat_last;
   logic                    in_scan;
   logic                    hs;

   // Occupancy of the incoming vector, used only at the moment start is taken.
   always_comb begin
      start_mask = '0;
      for (int k = 0; k < N_SLOT; k++) begin
         start_mask[k] = (slot_extract(index_vec, SLOT_W'(k)) != '0);
      end
   end

   lsb_prio_enc #(
      .N (N_SLOT),
      .W (SLOT_W)
   ) u_enc (
      .mask    (pend_mask),
      .idx     (cur_slot),
      .onehot  (cur_oh),
      .one_set (one_left)
   );

   assign cur_val = slot_extract(snap, cur_slot);

`ifdef Q_ADDR_DEG_LIMIT_EN
   logic [SLOT_W-1:0] lim_q;
   // Limit reached when this beat would be number lim_q (degree counts accepted beats).
   assign lim_hit = (lim_q != '0) && (degree == lim_q - 1'b1);
`else
   assign lim_hit = 1'b0;
`endif

   assign beat_last = one_left | lim_hit;
   assign in_scan   = (state == SCAN);
   assign hs        = in_scan & addr_ready;

   // Beat fields are gated so every output reads zero outside SCAN.
   assign addr_valid = in_scan;
   assign busy       = in_scan;
   assign done       = (state == DONE);
   assign addr       = in_scan ? cur_val - 1'b1 : '0;
   assign addr_slot  = in_scan ? cur_slot : '0;
   assign addr_last  = in_scan & beat_last;

   // Row FSM: snapshot on start, retire one slot per handshake, single DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         snap      <= '0;
         pend_mask <= '0;
         degree    <= '0;
`ifdef Q_ADDR_DEG_LIMIT_EN
         lim_q     <= '0;
         deg_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  snap      <= index_vec;
                  pend_mask <= start_mask;
                  degree    <= '0;
`ifdef Q_ADDR_DEG_LIMIT_EN
                  lim_q     <= deg_limit;
                  deg_err   <= 1'b0;
`endif
                  state     <= (start_mask == '0) ? DONE : SCAN;
               end
            end
            SCAN: begin
               if (hs) begin
                  pend_mask <= pend_mask & ~cur_oh;
                  degree    <= degree + 1'b1;
                  if (beat_last) begin
                     state <= DONE;
`ifdef Q_ADDR_DEG_LIMIT_EN
                     // Slots still pending after the final beat means the row was truncated.
                     if ((pend_mask & ~cur_oh) != '0) deg_err <= 1'b1;
`endif
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
